// File: rtl/fetch_port_pkg.sv
// Shared definitions for the fetch-side instruction port: FSM encoding and
// the word returned to fetch while the addressed instruction is absent.
package fetch_port_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_port_entry.sv
// One line-buffer entry: tag/data/err/valid with fill, invalidate and two
// tag comparators (current fetch word and its sequential successor).
module fetch_port_entry #(
  parameter logic [29:0] RESET_TAG = 30'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fill_i,
  input  logic        inval_i,
  input  logic [29:0] fill_tag_i,
  input  logic [31:0] fill_data_i,
  input  logic        fill_err_i,
  input  logic [29:0] cmp_a_i,
  input  logic [29:0] cmp_b_i,
  output logic        hit_a_o,
  output logic        hit_b_o,
  output logic [31:0] data_o,
  output logic        err_o
);

  logic        valid_q;
  logic [29:0] tag_q;
  logic [31:0] data_q;
  logic        err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      tag_q   <= RESET_TAG;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else if (inval_i) begin
      valid_q <= 1'b0;
    end else if (fill_i) begin
      valid_q <= 1'b1;
      tag_q   <= fill_tag_i;
      data_q  <= fill_data_i;
      err_q   <= fill_err_i;
    end
  end

  assign hit_a_o = valid_q && (tag_q == cmp_a_i);
  assign hit_b_o = valid_q && (tag_q == cmp_b_i);
  assign data_o  = data_q;
  assign err_o   = err_q;

endmodule

// File: rtl/fetch_port.sv
// Instruction-fetch responder: 2-entry line buffer filled over a
// request/acknowledge memory bus, with optional next-sequential prefetch.
module fetch_port
  import fetch_port_pkg::*;
#(
  parameter int          ENABLE_PREFETCH = 1,
  parameter logic [31:0] RESET_VECTOR    = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] fetch_address,
  output logic [31:0] fetch_data,
  output logic        fetch_ready,
  output logic        fetch_error,
  output logic        fetch_stall,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err
);

  state_e      state_q, state_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        drop_q, drop_d;
  logic        ptr_q, ptr_d;

  logic [29:0] cur_tag, next_tag;
  logic [1:0]  hit_a, hit_b, fill;
  logic [31:0] data_e [2];
  logic [1:0]  err_e;
  logic        fetch_hit, next_present, ack_v, fill_en, victim;

  assign cur_tag      = fetch_address[31:2];
  assign next_tag     = cur_tag + 30'd1;
  assign fetch_hit    = |hit_a;
  assign next_present = |hit_b;
  assign ack_v        = mem_ack && (state_q == WAIT);
  // A flush in the ack cycle discards that response just like a pending drop.
  assign fill_en      = ack_v && !drop_q && !flush;
  // Never evict the word fetch is currently consuming.
  assign victim       = hit_a[ptr_q] ? ~ptr_q : ptr_q;
  assign fill         = {fill_en & victim, fill_en & ~victim};

  for (genvar g = 0; g < 2; g++) begin : g_entry
    fetch_port_entry #(
      .RESET_TAG (RESET_VECTOR[31:2])
    ) u_entry (
      .clk_i       (clk),
      .rst_i       (reset),
      .fill_i      (fill[g]),
      .inval_i     (flush),
      .fill_tag_i  (mem_addr_q[31:2]),
      .fill_data_i (mem_rdata),
      .fill_err_i  (mem_err),
      .cmp_a_i     (cur_tag),
      .cmp_b_i     (next_tag),
      .hit_a_o     (hit_a[g]),
      .hit_b_o     (hit_b[g]),
      .data_o      (data_e[g]),
      .err_o       (err_e[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      mem_addr_q <= RESET_VECTOR;
      drop_q     <= 1'b0;
      ptr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      drop_q     <= drop_d;
      ptr_q      <= ptr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    drop_d     = drop_q;
    ptr_d      = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (!flush) begin
          if (!fetch_hit) begin
            state_d    = WAIT;
            mem_addr_d = fetch_address & 32'hFFFF_FFFC;
          end else if ((ENABLE_PREFETCH != 0) && !next_present) begin
            state_d    = WAIT;
            mem_addr_d = {next_tag, 2'b00};
          end
        end
      end
      WAIT: begin
        if (ack_v) begin
          state_d = IDLE;
          drop_d  = 1'b0;
          if (fill_en) ptr_d = ~ptr_q;
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fetch_data  = NOP;
    fetch_error = 1'b0;
    if (hit_a[0]) begin
      fetch_data  = data_e[0];
      fetch_error = err_e[0];
    end else if (hit_a[1]) begin
      fetch_data  = data_e[1];
      fetch_error = err_e[1];
    end
  end

  assign fetch_ready = fetch_hit;
  assign fetch_stall = !fetch_hit;
  assign mem_req     = (state_q == WAIT);
  assign mem_addr    = mem_addr_q;

endmodule

// File: tb/tb_fetch_port.sv
// Bench for fetch_port: directed scenarios plus a randomized run against a
// behavioural model of the line buffer and its bus transactions.
module tb_fetch_port;

  localparam logic [31:0] NOPW = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, flush, mem_ack, mem_err, mem_ack0;
  logic [31:0] fetch_address, mem_rdata;
  logic [31:0] fetch_data, mem_addr, fetch_data0, mem_addr0;
  logic        fetch_ready, fetch_error, fetch_stall, mem_req;
  logic        fetch_ready0, fetch_error0, fetch_stall0, mem_req0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_port #(.ENABLE_PREFETCH(1), .RESET_VECTOR(32'h8000_0000)) dut (
    .clk(clk), .reset(reset), .fetch_address(fetch_address),
    .fetch_data(fetch_data), .fetch_ready(fetch_ready), .fetch_error(fetch_error),
    .fetch_stall(fetch_stall), .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err));

  fetch_port #(.ENABLE_PREFETCH(0), .RESET_VECTOR(32'h8000_0000)) dut_nopf (
    .clk(clk), .reset(reset), .fetch_address(fetch_address),
    .fetch_data(fetch_data0), .fetch_ready(fetch_ready0), .fetch_error(fetch_error0),
    .fetch_stall(fetch_stall0), .flush(flush), .mem_req(mem_req0), .mem_addr(mem_addr0),
    .mem_ack(mem_ack0), .mem_rdata(mem_rdata), .mem_err(mem_err));

  // Reference model: two cached words plus at most one outstanding bus read.
  bit          m_v [2];
  logic [29:0] m_t [2];
  logic [31:0] m_d [2];
  bit          m_e [2];
  bit          m_ptr, m_pend, m_drop;
  logic [31:0] m_addr;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [31:0] a);
    reset = 1'b1; flush = 1'b0; mem_ack = 1'b0; mem_ack0 = 1'b0;
    mem_err = 1'b0; mem_rdata = '0; fetch_address = a;
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_v[i] = 0; m_t[i] = 30'h2000_0000; m_d[i] = '0; m_e[i] = 0;
    end
    m_ptr = 0; m_pend = 0; m_drop = 0; m_addr = 32'h8000_0000;
  endtask

  function automatic bit m_has(input logic [31:0] a, input int i);
    return m_v[i] && (m_t[i] == a[31:2]);
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'd3) ^ 32'h1234_5678;
  endfunction

  function automatic logic mem_bad(input logic [31:0] a);
    return a[4:2] == 3'd5;
  endfunction

  function automatic logic [31:0] pick_addr();
    int k = $urandom_range(0, 9);
    if (k < 8) return 32'h8000_0000 + 32'(k * 4);
    if (k == 8) return 32'hFFFF_FFFC;
    return 32'h0000_0000;
  endfunction

  task automatic m_update(input logic [31:0] fa, input logic fl, input logic ak,
                          input logic [31:0] rd, input logic er, input logic rs);
    bit h0, h1, vic;
    logic [31:0] na;
    if (rs) begin
      m_reset();
      return;
    end
    h0 = m_has(fa, 0);
    h1 = m_has(fa, 1);
    na = {fa[31:2], 2'b00} + 32'd4;
    if (m_pend) begin
      if (ak) begin
        if (!m_drop && !fl) begin
          vic = (m_ptr ? h1 : h0) ? ~m_ptr : m_ptr;
          m_v[vic] = 1; m_t[vic] = m_addr[31:2]; m_d[vic] = rd; m_e[vic] = er;
          m_ptr = ~m_ptr;
        end
        m_pend = 0; m_drop = 0;
      end else if (fl) begin
        m_drop = 1;
      end
    end else if (!fl) begin
      if (!(h0 || h1)) begin
        m_pend = 1; m_addr = {fa[31:2], 2'b00};
      end else if (!(m_has(na, 0) || m_has(na, 1))) begin
        m_pend = 1; m_addr = na;
      end
    end
    if (fl) begin
      m_v[0] = 0; m_v[1] = 0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; mem_ack = 1'b0; mem_ack0 = 1'b0;
    mem_err = 1'b0; mem_rdata = '0; fetch_address = 32'h8000_0000;
    step(); step(); #1;
    checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", fetch_ready); end
    checks++; if (fetch_stall !== 1'b1) begin errors++; $display("FAIL reset_stall got=%b exp=1", fetch_stall); end
    checks++; if (fetch_error !== 1'b0) begin errors++; $display("FAIL reset_error got=%b exp=0", fetch_error); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", mem_req); end
    checks++; if (mem_addr !== 32'h8000_0000) begin errors++; $display("FAIL reset_addr got=%h exp=80000000", mem_addr); end
    checks++; if (fetch_data !== NOPW) begin errors++; $display("FAIL reset_data got=%h exp=%h", fetch_data, NOPW); end
    reset = 1'b0;
  endtask

  task automatic test_cold_miss();
    do_reset(32'h8000_0000);
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) step();
      mem_ack = (c == 4); mem_ack0 = (c == 4); mem_rdata = 32'h0000_0297;
      #1;
      checks++; if (fetch_stall !== (c < 5)) begin errors++; $display("FAIL cold_stall c%0d got=%b exp=%b", c, fetch_stall, (c < 5)); end
      if (c == 0) begin
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL cold_req0 got=%b exp=0", mem_req); end
      end
      if (c == 1) begin
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h8000_0000) begin errors++; $display("FAIL cold_req1 got=%b/%h exp=1/80000000", mem_req, mem_addr); end
      end
    end
    checks++; if (fetch_ready !== 1'b1 || fetch_data !== 32'h0000_0297) begin errors++; $display("FAIL cold_fill got=%b/%h exp=1/00000297", fetch_ready, fetch_data); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL cold_idle got=%b exp=0", mem_req); end
    mem_ack = 1'b0; mem_ack0 = 1'b0;
  endtask

  task automatic test_prefetch();
    do_reset(32'h8000_0000);
    step(); mem_ack = 1'b1; mem_ack0 = 1'b1; mem_rdata = 32'h0000_0297; #1;
    step(); mem_ack = 1'b0; mem_ack0 = 1'b0; #1;
    checks++; if (fetch_ready0 !== 1'b1) begin errors++; $display("FAIL nopf_fill got=%b exp=1", fetch_ready0); end
    step(); #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h8000_0004) begin errors++; $display("FAIL pf_req got=%b/%h exp=1/80000004", mem_req, mem_addr); end
    checks++; if (mem_req0 !== 1'b0) begin errors++; $display("FAIL nopf_req got=%b exp=0", mem_req0); end
    mem_ack = 1'b1; mem_rdata = 32'h0000_0517;
    step(); mem_ack = 1'b0; fetch_address = 32'h8000_0004; #1;
    checks++; if (fetch_ready !== 1'b1 || fetch_data !== 32'h0000_0517) begin errors++; $display("FAIL pf_hit got=%b/%h exp=1/00000517", fetch_ready, fetch_data); end
    checks++; if (mem_req0 !== 1'b0) begin errors++; $display("FAIL nopf_req2 got=%b exp=0", mem_req0); end
  endtask

  task automatic test_redirect();
    do_reset(32'h8000_0010);
    step(); #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h8000_0010) begin errors++; $display("FAIL redir_req got=%b/%h exp=1/80000010", mem_req, mem_addr); end
    step(); fetch_address = 32'h8000_0100; #1;
    checks++; if (mem_addr !== 32'h8000_0010 || fetch_ready !== 1'b0) begin errors++; $display("FAIL redir_hold got=%h/%b exp=80000010/0", mem_addr, fetch_ready); end
    step(); mem_ack = 1'b1; mem_rdata = 32'hAAAA_0001; #1;
    step(); mem_ack = 1'b0; #1;
    checks++; if (mem_req !== 1'b0 || fetch_ready !== 1'b0) begin errors++; $display("FAIL redir_idle got=%b/%b exp=0/0", mem_req, fetch_ready); end
    step(); #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h8000_0100) begin errors++; $display("FAIL redir_new got=%b/%h exp=1/80000100", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'hBBBB_0002;
    step(); mem_ack = 1'b0; #1;
    checks++; if (fetch_ready !== 1'b1 || fetch_data !== 32'hBBBB_0002) begin errors++; $display("FAIL redir_fill2 got=%b/%h exp=1/bbbb0002", fetch_ready, fetch_data); end
    fetch_address = 32'h8000_0010; #1;
    checks++; if (fetch_ready !== 1'b1 || fetch_data !== 32'hAAAA_0001) begin errors++; $display("FAIL redir_fill1 got=%b/%h exp=1/aaaa0001", fetch_ready, fetch_data); end
  endtask

  task automatic test_flush_wait();
    do_reset(32'h8000_0008);
    step(); #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h8000_0008) begin errors++; $display("FAIL flush_req got=%b/%h exp=1/80000008", mem_req, mem_addr); end
    step(); flush = 1'b1; #1;
    step(); flush = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hDEAD_0008; #1;
    step(); mem_ack = 1'b0; #1;
    checks++; if (fetch_ready !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL flush_drop got=%b/%b exp=0/0", fetch_ready, mem_req); end
    step(); #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h8000_0008) begin errors++; $display("FAIL flush_rereq got=%b/%h exp=1/80000008", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'h0000_8008;
    step(); mem_ack = 1'b0; #1;
    checks++; if (fetch_ready !== 1'b1 || fetch_data !== 32'h0000_8008) begin errors++; $display("FAIL flush_refill got=%b/%h exp=1/00008008", fetch_ready, fetch_data); end
  endtask

  task automatic test_bus_error();
    do_reset(32'h8000_0020);
    step(); mem_ack = 1'b1; mem_err = 1'b1; mem_rdata = 32'h0000_DEAD; #1;
    step(); mem_ack = 1'b0; mem_err = 1'b0; #1;
    checks++; if (fetch_ready !== 1'b1 || fetch_error !== 1'b1) begin errors++; $display("FAIL berr_hit got=%b/%b exp=1/1", fetch_ready, fetch_error); end
    flush = 1'b1;
    step(); flush = 1'b0; #1;
    checks++; if (fetch_ready !== 1'b0 || fetch_error !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL berr_flush got=%b/%b/%b exp=0/0/0", fetch_ready, fetch_error, mem_req); end
    step(); #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h8000_0020) begin errors++; $display("FAIL berr_rereq got=%b/%h exp=1/80000020", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'h0001_3579;
    step(); mem_ack = 1'b0; #1;
    checks++; if (fetch_ready !== 1'b1 || fetch_error !== 1'b0 || fetch_data !== 32'h0001_3579) begin errors++; $display("FAIL berr_clean got=%b/%b/%h exp=1/0/00013579", fetch_ready, fetch_error, fetch_data); end
  endtask

  task automatic test_reset_wait_wrap();
    do_reset(32'h8000_0040);
    step(); #1;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rstw_req got=%b exp=1", mem_req); end
    reset = 1'b1;
    step(); reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0000_0BAD; #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rstw_drop got=%b exp=0", mem_req); end
    step(); mem_ack = 1'b0; #1;
    checks++; if (fetch_ready !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h8000_0040) begin errors++; $display("FAIL rstw_ignore got=%b/%b/%h exp=0/1/80000040", fetch_ready, mem_req, mem_addr); end
    do_reset(32'hFFFF_FFFC);
    step(); mem_ack = 1'b1; mem_rdata = 32'h0000_1111; #1;
    checks++; if (mem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req got=%h exp=fffffffc", mem_addr); end
    step(); mem_ack = 1'b0; #1;
    checks++; if (fetch_ready !== 1'b1 || fetch_data !== 32'h0000_1111) begin errors++; $display("FAIL wrap_hit got=%b/%h exp=1/00001111", fetch_ready, fetch_data); end
    step(); #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0000) begin errors++; $display("FAIL wrap_pf got=%b/%h exp=1/00000000", mem_req, mem_addr); end
  endtask

  task automatic test_random();
    logic [31:0] fa, rd, ed;
    logic        fl, ak, er, rs, er_exp, rdy;
    int          dly;
    do_reset(32'h8000_0000);
    m_reset();
    fa = 32'h8000_0000;
    dly = 1;
    for (int i = 0; i < 1500; i++) begin
      rs = ($urandom_range(0, 149) == 0);
      fl = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0) fa = pick_addr();
      ak = 1'b0; rd = $urandom; er = 1'($urandom_range(0, 1));
      if (m_pend) begin
        if (dly == 0) begin
          ak = 1'b1; rd = mem_word(m_addr); er = mem_bad(m_addr);
          dly = $urandom_range(0, 3);
        end else dly--;
      end else if ($urandom_range(0, 9) == 0) ak = 1'b1;
      reset = rs; flush = fl; fetch_address = fa; mem_ack = ak;
      mem_rdata = rd; mem_err = er; mem_ack0 = 1'b0;
      #1;
      rdy    = m_has(fa, 0) || m_has(fa, 1);
      ed     = m_has(fa, 0) ? m_d[0] : (m_has(fa, 1) ? m_d[1] : NOPW);
      er_exp = m_has(fa, 0) ? m_e[0] : (m_has(fa, 1) ? m_e[1] : 1'b0);
      checks++; if (fetch_ready !== rdy) begin errors++; $display("FAIL rnd_ready i%0d got=%b exp=%b", i, fetch_ready, rdy); end
      checks++; if (fetch_stall !== !rdy) begin errors++; $display("FAIL rnd_stall i%0d got=%b exp=%b", i, fetch_stall, !rdy); end
      checks++; if (fetch_data !== ed) begin errors++; $display("FAIL rnd_data i%0d got=%h exp=%h", i, fetch_data, ed); end
      checks++; if (fetch_error !== er_exp) begin errors++; $display("FAIL rnd_error i%0d got=%b exp=%b", i, fetch_error, er_exp); end
      checks++; if (mem_req !== m_pend) begin errors++; $display("FAIL rnd_req i%0d got=%b exp=%b", i, mem_req, m_pend); end
      checks++; if (mem_addr !== m_addr) begin errors++; $display("FAIL rnd_addr i%0d got=%h exp=%h", i, mem_addr, m_addr); end
      m_update(fa, fl, ak, rd, er, rs);
      step();
    end
    reset = 1'b0; flush = 1'b0; mem_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_prefetch();
    test_redirect();
    test_flush_wait();
    test_bus_error();
    test_reset_wait_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
